// File: rtl/sample_interpolator.sv
// sample_interpolator: upsamples a sample stream by 2^RATE_LOG2 output ticks per input sample.
// Define SAMPLE_INTERPOLATOR_LINEAR_EN for linear interpolation; otherwise zero-order hold.
module sample_interpolator #(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 256,
    parameter int RATE_LOG2 = 2
) (
    input  logic              ipClk,
    input  logic              ipReset,
    input  logic              ipEnable,
    input  logic [DATA_W-1:0] ipSample,
    input  logic              ipValid,
    output logic              opReady,
    output logic [DATA_W-1:0] opSample,
    output logic              opStrobe,
    output logic [15:0]       opUnderrunCount,
    output logic [1:0]        opState
);
    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int STEP_W = (RATE_LOG2 > 0) ? RATE_LOG2 : 1;
    localparam int ACC_W  = DATA_W + 1 + RATE_LOG2;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'((1 << RATE_LOG2) - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2, UNDERRUN = 2'd3} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic signed [DATA_W-1:0] cur_q, cur_d, next_q, next_d, pend_q, pend_d, out_q, out_d;
    logic                     pend_valid_q, pend_valid_d, got_q, got_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_new;
    logic [15:0]              urun_q, urun_d;
    logic                     tick, seg_end, accept;

    assign tick    = (state_q != IDLE) && (cnt_q == CNT_LAST);
    assign seg_end = tick && (state_q == RUN) && (step_q == STEP_LAST);
    assign accept  = ipValid && opReady;

`ifdef SAMPLE_INTERPOLATOR_LINEAR_EN
    logic signed [DATA_W:0] delta;
    // One extra bit keeps Next-Cur exact for full-scale swings such as 0x7FFF -> 0x8000.
    assign delta   = {next_q[DATA_W-1], next_q} - {cur_q[DATA_W-1], cur_q};
    assign acc_new = acc_q + ACC_W'(delta);
`else
    assign acc_new = acc_q;
`endif

    always_ff @(posedge ipClk) begin
        state_q <= ipReset ? IDLE : state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!ipEnable)
            state_d = IDLE;
        else if (state_q == IDLE)
            state_d = PRIME;
        else if (state_q == PRIME && accept && got_q)
            state_d = RUN;
        else if (seg_end && !pend_valid_q && !accept)
            state_d = UNDERRUN;
        else if (state_q == UNDERRUN && accept)
            state_d = RUN;
    end

    // Handshake and strobe are withheld while leaving for IDLE so no sample is silently dropped.
    assign opReady  = ipEnable && !ipReset &&
                      (state_q == PRIME || state_q == UNDERRUN || (state_q == RUN && !pend_valid_q));
    assign opStrobe = ipEnable && !ipReset && tick && (state_q == RUN);
    assign opState  = state_q;
    assign opSample = out_q;
    assign opUnderrunCount = urun_q;

    always_comb begin
        cnt_d        = (state_q == IDLE || !ipEnable || tick) ? '0 : cnt_q + CNT_W'(1);
        step_d       = step_q;
        cur_d        = cur_q;
        next_d       = next_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        got_d        = got_q;
        acc_d        = acc_q;
        out_d        = out_q;
        urun_d       = urun_q;
        if (!ipEnable) begin
            pend_valid_d = 1'b0;
            step_d       = '0;
            out_d        = '0;
            got_d        = 1'b0;
        end else begin
            case (state_q)
                IDLE: out_d = '0;
                PRIME: begin
                    if (accept && !got_q) begin
                        cur_d = $signed(ipSample);
                        got_d = 1'b1;
                    end else if (accept) begin
                        next_d = $signed(ipSample);
                        acc_d  = ACC_W'(cur_q) <<< RATE_LOG2;
                        out_d  = cur_q;
                        step_d = '0;
                        got_d  = 1'b0;
                    end
                end
                RUN: begin
                    if (accept && !seg_end) begin
                        pend_d       = $signed(ipSample);
                        pend_valid_d = 1'b1;
                    end
                    if (tick) begin
                        acc_d  = acc_new;
                        out_d  = seg_end ? next_q : acc_new[RATE_LOG2+DATA_W-1:RATE_LOG2];
                        step_d = seg_end ? '0 : step_q + STEP_W'(1);
                    end
                    if (seg_end) begin
                        cur_d = next_q;
                        acc_d = ACC_W'(next_q) <<< RATE_LOG2;
                        if (pend_valid_q) begin
                            next_d       = pend_q;
                            pend_valid_d = 1'b0;
                        end else if (accept)
                            next_d = $signed(ipSample);
                        else
                            urun_d = (urun_q == 16'hFFFF) ? urun_q : urun_q + 16'd1;
                    end
                end
                UNDERRUN: begin
                    if (accept) begin
                        next_d = $signed(ipSample);
                        step_d = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            cnt_q        <= '0;
            step_q       <= '0;
            cur_q        <= '0;
            next_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            got_q        <= 1'b0;
            acc_q        <= '0;
            out_q        <= '0;
            urun_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            cur_q        <= cur_d;
            next_q       <= next_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            got_q        <= got_d;
            acc_q        <= acc_d;
            out_q        <= out_d;
            urun_q       <= urun_d;
        end
    end
endmodule

// File: tb/tb_sample_interpolator.sv
// tb_sample_interpolator: directed checks of sample_interpolator with CLK_DIV=4, RATE_LOG2=2.
// Expectations follow SAMPLE_INTERPOLATOR_LINEAR_EN when defined, zero-order hold otherwise.
module tb_sample_interpolator;
`ifdef SAMPLE_INTERPOLATOR_LINEAR_EN
    localparam bit LIN = 1'b1;
`else
    localparam bit LIN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        ipReset, ipEnable, ipValid;
    logic [15:0] ipSample;
    logic        opReady, opStrobe;
    logic [15:0] opSample, opUnderrunCount;
    logic [1:0]  opState;
    int          n_chk = 0, n_bad = 0, cyc = 0, last_strobe = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sample_interpolator #(.DATA_W(16), .CLK_DIV(4), .RATE_LOG2(2)) dut (
        .ipClk(clk),
        .ipReset(ipReset),
        .ipEnable(ipEnable),
        .ipSample(ipSample),
        .ipValid(ipValid),
        .opReady(opReady),
        .opSample(opSample),
        .opStrobe(opStrobe),
        .opUnderrunCount(opUnderrunCount),
        .opState(opState)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        ipReset = 1'b1;
        repeat (2) @(negedge clk);
        ipReset = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        int n = 0;
        ipSample = v;
        ipValid  = 1'b1;
        while (opReady !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(n < 60), 1);
        @(negedge clk);
        ipValid = 1'b0;
    endtask

    // Waits for a tick strobe, then checks the value it loaded into opSample.
    task automatic exp_strobe(input string tag, input logic [15:0] exp, input bit gap_chk);
        int n = 0;
        while (opStrobe !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, 32'(n < 60), 1);
        if (gap_chk) chk({tag, "_gap"}, cyc - last_strobe, 4);
        last_strobe = cyc;
        @(negedge clk);
        chk(tag, opSample, exp);
    endtask

    initial begin
        int n, s;
        ipReset = 1'b1; ipEnable = 1'b1; ipValid = 1'b0; ipSample = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", opState, 0);
        chk("rst_ready", opReady, 0);
        chk("rst_out", opSample, 0);
        chk("rst_strobe", opStrobe, 0);
        chk("rst_urun", opUnderrunCount, 0);
        ipReset = 1'b0;

        send(16'd0);
        send(16'd400);
        chk("t1_prime_out", opSample, 0);
        chk("t1_run", opState, 2);
        ipSample = 16'd800;
        ipValid  = 1'b1;
        for (int i = 0; i < 8; i++)
            exp_strobe("t1_ramp", LIN ? 16'(100 * (i + 1)) : (i < 3 ? 16'd0 : i < 7 ? 16'd400 : 16'd800), i > 0);
        ipValid = 1'b0;

        do_reset();
        send(16'd0);
        send(16'd400);
        for (int i = 0; i < 4; i++)
            exp_strobe("t3_ramp", LIN ? 16'(100 * (i + 1)) : (i < 3 ? 16'd0 : 16'd400), 1'b0);
        s = 0;
        repeat (8) begin
            @(negedge clk);
            s += int'(opStrobe);
        end
        chk("t3_nostrobe", s, 0);
        chk("t3_state", opState, 3);
        chk("t3_urun", opUnderrunCount, 1);
        chk("t3_hold", opSample, 400);
        chk("t3_ready", opReady, 1);
        send(16'd0);
        for (int i = 0; i < 4; i++)
            exp_strobe("t3_down", LIN ? 16'(300 - 100 * i) : (i < 3 ? 16'd400 : 16'd0), 1'b0);
        chk("t3_urun2", opUnderrunCount, 2);
        send(16'd40);
        exp_strobe("t3_mid", LIN ? 16'd10 : 16'd0, 1'b0);
        chk("t3_mid_state", opState, 2);
        ipReset = 1'b1;
        @(negedge clk);
        ipReset = 1'b0;
        chk("mid_rst_out", opSample, 0);
        chk("mid_rst_ready", opReady, 0);
        chk("mid_rst_state", opState, 0);
        chk("mid_rst_urun", opUnderrunCount, 0);
        chk("mid_rst_strobe", opStrobe, 0);

        send(16'd100);
        send(16'hFF9C);
        for (int i = 0; i < 4; i++)
            exp_strobe("t2_neg", LIN ? (i == 0 ? 16'd50 : i == 1 ? 16'd0 : i == 2 ? 16'hFFCE : 16'hFF9C)
                                     : (i < 3 ? 16'd100 : 16'hFF9C), 1'b0);
        ipEnable = 1'b0;
        @(negedge clk);
        chk("dis_state", opState, 0);
        chk("dis_out", opSample, 0);
        chk("dis_ready", opReady, 0);
        chk("dis_urun", opUnderrunCount, 1);
        @(negedge clk);
        ipEnable = 1'b1;
        send(16'h7FFF);
        send(16'h8000);
        chk("t2_max_start", opSample, 16'h7FFF);
        for (int i = 0; i < 4; i++)
            exp_strobe("t2_wrap", LIN ? (i == 0 ? 16'h3FFF : i == 1 ? 16'hFFFF : i == 2 ? 16'hBFFF : 16'h8000)
                                      : (i < 3 ? 16'h7FFF : 16'h8000), 1'b0);

        do_reset();
        send(16'd0);
        send(16'd400);
        for (int i = 0; i < 3; i++)
            exp_strobe("t4_ramp", LIN ? 16'(100 * (i + 1)) : 16'd0, 1'b0);
        n = 0;
        while (opStrobe !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("t4_seen", 32'(n < 60), 1);
        ipSample = 16'd800;
        ipValid  = 1'b1;
        chk("t4_ready", opReady, 1);
        @(negedge clk);
        ipValid = 1'b0;
        chk("t4_seg_out", opSample, 400);
        chk("t4_state", opState, 2);
        chk("t4_urun", opUnderrunCount, 0);
        for (int i = 0; i < 4; i++)
            exp_strobe("t4_next", LIN ? 16'(500 + 100 * i) : (i < 3 ? 16'd400 : 16'd800), 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end
endmodule
